// File: rtl/q_sys_batch_sequencer.sv
// Avalon-MM batch sequencer: issues FIRST..FIRST+COUNT-1 to the datapath, one batch at a time.
// Optional per-batch completion watchdog is built when Q_SYS_BATCH_TIMEOUT_EN is defined.
module q_sys_batch_sequencer #(
  parameter int BATNUM_W       = 10,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [BATNUM_W-1:0] batnum,
  output logic                batch_valid,
  input  logic                batch_ready,
  input  logic                batch_done,
  input  logic                batch_err,
  output logic                busy,
  output logic                irq
);

  // Handshake: batch_valid/batnum are held stable until the cycle batch_valid & batch_ready
  // are both high at a clock edge; batch_done is only honoured after that acceptance.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_FIRST  = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]          state;
  logic                irq_en;
  logic [BATNUM_W-1:0] first;
  logic [BATNUM_W:0]   count;
  logic [BATNUM_W:0]   remaining;
  logic [15:0]         err_count;
  logic                done_flag;
  logic                aborted_flag;
  logic                timeout_flag;
  logic                expire;
  logic                wr;
  logic                start;
  logic                abort;
  logic                unused_bits;

  assign wr    = chipselect & ~write_n;
  assign start = wr && (address == A_CTRL) && writedata[0];
  assign abort = wr && (address == A_CTRL) && writedata[1];
  assign unused_bits = ^writedata[31:BATNUM_W+1];

  assign busy        = (state != S_IDLE);
  assign batch_valid = (state == S_ISSUE);
  assign irq         = irq_en & (done_flag | timeout_flag | aborted_flag);

`ifdef Q_SYS_BATCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] wait_cnt;

  // Expiry yields to a same-cycle batch_done and to abort.
  assign expire = (state == S_WAIT) && !batch_done && !abort && (wait_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt     <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (state == S_ISSUE) wait_cnt <= '0;
      else if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
      if (state == S_IDLE && start && !abort && count != '0) timeout_flag <= 1'b0;
      else if (expire) timeout_flag <= 1'b1;
      else if (wr && address == A_STATUS && writedata[2]) timeout_flag <= 1'b0;
    end
  end
`else
  assign expire       = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      irq_en       <= 1'b0;
      first        <= '0;
      count        <= '0;
      remaining    <= '0;
      batnum       <= '0;
      err_count    <= '0;
      done_flag    <= 1'b0;
      aborted_flag <= 1'b0;
    end else begin
      if (wr && address == A_CTRL) irq_en <= writedata[2];
      if (wr && address == A_FIRST && state == S_IDLE) first <= writedata[BATNUM_W-1:0];
      if (wr && address == A_COUNT && state == S_IDLE) count <= writedata[BATNUM_W:0];
      if (wr && address == A_STATUS) begin
        if (writedata[1]) done_flag    <= 1'b0;
        if (writedata[3]) aborted_flag <= 1'b0;
      end

      // FSM events are placed after the W1C clears so a same-cycle set wins.
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            if (count != '0) begin
              state        <= S_ISSUE;
              batnum       <= first;
              remaining    <= count;
              err_count    <= '0;
              done_flag    <= 1'b0;
              aborted_flag <= 1'b0;
            end else begin
              done_flag <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (abort) begin
            state        <= S_IDLE;
            aborted_flag <= 1'b1;
          end else if (batch_ready) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (abort) begin
            state        <= S_IDLE;
            aborted_flag <= 1'b1;
          end else if (batch_done) begin
            if (batch_err && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            if (remaining == 1) begin
              state     <= S_IDLE;
              done_flag <= 1'b1;
            end else begin
              batnum    <= batnum + 1'b1;
              remaining <= remaining - 1'b1;
              state     <= S_ISSUE;
            end
          end else if (expire) begin
            state     <= S_IDLE;
            done_flag <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      A_CTRL:   readdata = {29'b0, irq_en, 2'b00};
      A_FIRST:  readdata = {{(32-BATNUM_W){1'b0}}, first};
      A_COUNT:  readdata = {{(31-BATNUM_W){1'b0}}, count};
      A_STATUS: readdata = {err_count, 12'b0, aborted_flag, timeout_flag, done_flag, busy};
      default:  readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_q_sys_batch_sequencer.sv
// Directed + randomized bench for q_sys_batch_sequencer; timeout scenario needs Q_SYS_BATCH_TIMEOUT_EN.
module tb_q_sys_batch_sequencer;
  localparam int W  = 10;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  batnum;
  logic          batch_valid;
  logic          batch_ready;
  logic          batch_done;
  logic          batch_err;
  logic          busy;
  logic          irq;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  bit irq_en_m = 1'b0;

  q_sys_batch_sequencer #(.BATNUM_W(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .batnum(batnum), .batch_valid(batch_valid), .batch_ready(batch_ready),
    .batch_done(batch_done), .batch_err(batch_err), .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] st(input int err, input bit ab, input bit to, input bit dn, input bit bs);
    logic [31:0] e;
    e = (err > 65535) ? 32'hFFFF : err;
    return {e[15:0], 12'b0, ab, to, dn, bs};
  endfunction

  // Inputs change on the falling edge; the write lands on the following rising edge.
  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic reg_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(tag, readdata, exp);
  endtask

  task automatic ctrl_write(input bit s, input bit ab, input bit ie);
    irq_en_m = ie;
    reg_write(2'd0, {29'b0, ie, ab, s});
  endtask

  // Model: batches are first..first+count-1 modulo 2^W; err_count = number of err-flagged dones.
  task automatic run_seq(input int first, input int count, input int hold, input int dly,
                         input bit rand_err, input logic [15:0] err_mask);
    int e;
    int h;
    int d;
    bit er;
    logic [W-1:0] cur;
    e = 0;
    exp_q.delete();
    for (int i = 0; i < count; i++) exp_q.push_back(W'((first + i) % (1 << W)));
    reg_write(2'd1, first);
    reg_write(2'd2, count);
    ctrl_write(1'b1, 1'b0, irq_en_m);
    for (int i = 0; i < count; i++) begin
      h = (hold < 0) ? $urandom_range(0, 3) : hold;
      d = (dly < 0) ? $urandom_range(0, 2) : dly;
      er = rand_err ? 1'($urandom_range(0, 1)) : err_mask[i];
      cur = exp_q.pop_front();
      chk("issue_valid", batch_valid, 1);
      chk("issue_busy", busy, 1);
      chk("issue_batnum", batnum, cur);
      for (int k = 0; k < h; k++) begin
        @(negedge clk);
        chk("hold_valid", batch_valid, 1);
        chk("hold_batnum", batnum, cur);
      end
      batch_ready = 1'b1;
      @(negedge clk);
      batch_ready = 1'b0;
      chk("accept_valid_low", batch_valid, 0);
      for (int k = 0; k < d; k++) begin
        @(negedge clk);
        chk("wait_valid_low", batch_valid, 0);
        chk("wait_busy", busy, 1);
      end
      batch_done = 1'b1; batch_err = er;
      @(negedge clk);
      batch_done = 1'b0; batch_err = 1'b0;
      if (er) e++;
    end
    chk("end_busy", busy, 0);
    chk("end_valid", batch_valid, 0);
    chk("end_irq", irq, irq_en_m);
    reg_chk("end_status", 2'd3, st(e, 0, 0, 1, 0));
  endtask

  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    batch_ready = 1'b0; batch_done = 1'b0; batch_err = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_batnum", batnum, 0);
    chk("rst_valid", batch_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_irq", irq, 0);
    for (int a = 0; a < 4; a++) reg_chk("rst_readdata", 2'(a), 32'h0);

    run_seq(5, 3, 0, 1, 1'b0, 16'h0000);
    reg_chk("first_rb", 2'd1, 32'd5);
    reg_chk("count_rb", 2'd2, 32'd3);

    irq_en_m = 1'b1;
    run_seq(1022, 4, -1, -1, 1'b0, 16'b1010);
    reg_chk("ctrl_rb", 2'd0, 32'h4);

    // COUNT=0: immediate done, no issue.
    reg_write(2'd2, 0);
    ctrl_write(1'b1, 1'b0, 1'b1);
    chk("zero_valid", batch_valid, 0);
    chk("zero_busy", busy, 0);
    chk("zero_irq", irq, 1);
    reg_chk("zero_status", 2'd3, st(2, 0, 0, 1, 0));
    reg_write(2'd3, 32'h2);
    chk("w1c_irq", irq, 0);
    reg_chk("w1c_status", 2'd3, st(2, 0, 0, 0, 0));

    // Stall, ignored writes while busy, abort in WAIT.
    reg_write(2'd1, 100);
    reg_write(2'd2, 2);
    ctrl_write(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      if (k == 4) reg_write(2'd1, 7);
      else if (k == 6) ctrl_write(1'b1, 1'b0, 1'b1);
      else @(negedge clk);
      chk("stall_valid", batch_valid, 1);
      chk("stall_batnum", batnum, 100);
    end
    reg_chk("busy_first_kept", 2'd1, 32'd100);
    batch_ready = 1'b1;
    @(negedge clk);
    batch_ready = 1'b0;
    chk("stall_accept", batch_valid, 0);
    ctrl_write(1'b0, 1'b1, 1'b1);
    chk("abort_busy", busy, 0);
    chk("abort_irq", irq, 1);
    reg_chk("abort_status", 2'd3, st(0, 1, 0, 0, 0));
    ctrl_write(1'b0, 1'b1, 1'b1);
    reg_chk("idle_abort_noop", 2'd3, st(0, 1, 0, 0, 0));
    reg_write(2'd3, 32'h8);
    reg_chk("w1c_aborted", 2'd3, st(0, 0, 0, 0, 0));

    // batch_done in IDLE, in ISSUE, and coincident with acceptance: all ignored.
    batch_done = 1'b1; batch_err = 1'b1;
    @(negedge clk);
    batch_done = 1'b0; batch_err = 1'b0;
    chk("idle_done_busy", busy, 0);
    reg_chk("idle_done_status", 2'd3, st(0, 0, 0, 0, 0));
    reg_write(2'd1, 300);
    ctrl_write(1'b1, 1'b1, 1'b0);
    chk("start_abort_same", busy, 0);
    ctrl_write(1'b1, 1'b0, 1'b0);
    batch_done = 1'b1; batch_err = 1'b1;
    @(negedge clk);
    chk("issue_done_valid", batch_valid, 1);
    chk("issue_done_batnum", batnum, 300);
    batch_ready = 1'b1;
    @(negedge clk);
    batch_ready = 1'b0; batch_done = 1'b0; batch_err = 1'b0;
    chk("coincident_valid", batch_valid, 0);
    chk("coincident_busy", busy, 1);
    batch_done = 1'b1;
    @(negedge clk);
    batch_done = 1'b0;
    chk("turnaround_valid", batch_valid, 1);
    chk("turnaround_batnum", batnum, 301);
    batch_ready = 1'b1;
    @(negedge clk);
    batch_ready = 1'b0;
    batch_done = 1'b1;
    @(negedge clk);
    batch_done = 1'b0;
    reg_chk("ignored_done_status", 2'd3, st(0, 0, 0, 1, 0));

    // Randomized runs against the model.
    for (int r = 0; r < 6; r++) begin
      irq_en_m = 1'($urandom_range(0, 1));
      run_seq($urandom_range(0, (1 << W) - 1), $urandom_range(1, 6), -1, -1, 1'b1, 16'h0);
    end

`ifdef Q_SYS_BATCH_TIMEOUT_EN
    reg_write(2'd1, 40);
    reg_write(2'd2, 2);
    ctrl_write(1'b1, 1'b0, 1'b1);
    batch_ready = 1'b1;
    @(negedge clk);
    batch_ready = 1'b0;
    for (int k = 0; k < TO - 1; k++) @(negedge clk);
    chk("to_before_busy", busy, 1);
    @(negedge clk);
    chk("to_busy", busy, 0);
    chk("to_irq", irq, 1);
    reg_chk("to_status", 2'd3, st(0, 0, 1, 1, 0));
`endif

    // Reset in the middle of WAIT.
    reg_write(2'd1, 9);
    reg_write(2'd2, 3);
    ctrl_write(1'b1, 1'b0, 1'b1);
    batch_ready = 1'b1;
    @(negedge clk);
    batch_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    irq_en_m = 1'b0;
    chk("mid_rst_batnum", batnum, 0);
    chk("mid_rst_valid", batch_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_irq", irq, 0);
    for (int a = 0; a < 4; a++) reg_chk("mid_rst_readdata", 2'(a), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
